// File: rtl/rgb_frame_sequencer_pkg.sv
// Shared definitions for the RGB frame sequencer: FSM encoding, header tag,
// byte positions inside the {G,R,B} colour word and error counter width.
package rgb_frame_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GET_G     = 3'd1,
    ST_GET_R     = 3'd2,
    ST_GET_B     = 3'd3,
    ST_WAIT_IDLE = 3'd4,
    ST_LOAD      = 3'd5
  } state_e;

  localparam logic [5:0] HEADER_TAG = 6'b101000;

  localparam int G_LSB = 16;
  localparam int R_LSB = 8;
  localparam int B_LSB = 0;

  localparam int ERR_W = 8;

endpackage

// File: rtl/byte_timeout_timer.sv
// Inter-byte timeout: counts while enabled, clear has priority, and expire
// is asserted combinationally in the cycle the count sits at TIMEOUT-1.
module byte_timeout_timer #(
  parameter int TIMEOUT = 100000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expire = enable && (cnt_q == LAST);

endmodule

// File: rtl/rgb_frame_sequencer.sv
// Assembles header+G+R+B UART frames and hands the colour to the addressed
// WS2812 strip driver with a one-cycle load once that driver is idle.
module rgb_frame_sequencer
  import rgb_frame_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 100000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  input  logic [3:0]  i_busy,
  output logic [23:0] o_din,
  output logic [1:0]  o_sel,
  output logic [3:0]  o_load,
  output logic        o_frame_done,
  output logic [7:0]  o_err_cnt
);

  state_e           state_q, state_d;
  logic [1:0]       ch_q, ch_d;
  logic [23:0]      colour_q, colour_d;
  logic [23:0]      din_q, din_d;
  logic [1:0]       sel_q, sel_d;
  logic [ERR_W-1:0] err_q;
  logic             err_inc;
  logic             tmr_clear, tmr_en, tmr_expire;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  byte_timeout_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .expire  (tmr_expire)
  );

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    colour_d  = colour_q;
    din_d     = din_q;
    sel_d     = sel_q;
    err_inc   = 1'b0;
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data[7:2] == HEADER_TAG) begin
            ch_d      = i_rx_data[1:0];
            tmr_clear = 1'b1;
            state_d   = ST_GET_G;
          end else begin
            err_inc = 1'b1;
          end
        end
      end

      // A byte arriving on the expiry cycle wins over the timeout.
      ST_GET_G, ST_GET_R, ST_GET_B: begin
        tmr_en = 1'b1;
        if (i_rx_valid) begin
          tmr_clear = 1'b1;
          case (state_q)
            ST_GET_G: begin
              colour_d[G_LSB +: 8] = i_rx_data;
              state_d              = ST_GET_R;
            end
            ST_GET_R: begin
              colour_d[R_LSB +: 8] = i_rx_data;
              state_d              = ST_GET_B;
            end
            default: begin
              colour_d[B_LSB +: 8] = i_rx_data;
              state_d              = ST_WAIT_IDLE;
            end
          endcase
        end else if (tmr_expire) begin
          colour_d = '0;
          err_inc  = 1'b1;
          state_d  = ST_IDLE;
        end
      end

      ST_WAIT_IDLE: begin
        err_inc = i_rx_valid;
        if (!i_busy[ch_q]) begin
          din_d   = colour_q;
          sel_d   = ch_q;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        err_inc = i_rx_valid;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      ch_q     <= '0;
      colour_q <= '0;
      din_q    <= '0;
      sel_q    <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      colour_q <= colour_d;
      din_q    <= din_d;
      sel_q    <= sel_d;
      if (err_inc) err_q <= sat_inc(err_q);
    end
  end

  always_comb begin
    o_load = '0;
    if (state_q == ST_LOAD) o_load[ch_q] = 1'b1;
  end

  assign o_frame_done = (state_q == ST_LOAD);
  assign o_din        = din_q;
  assign o_sel        = sel_q;
  assign o_err_cnt    = err_q;

endmodule

// File: tb/tb_rgb_frame_sequencer.sv
// Bench for rgb_frame_sequencer: frame vector table, scoreboard of expected
// loads, and hand-written timeout, busy, error and reset sequences.
module tb_rgb_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [3:0]  busy = 4'h0;
  logic [23:0] o_din;
  logic [1:0]  o_sel;
  logic [3:0]  o_load;
  logic        o_frame_done;
  logic [7:0]  o_err_cnt;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [23:0] din;
    logic [1:0]  sel;
    logic [3:0]  load;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [7:0]  hdr, g, r, b;
    logic [3:0]  busy;
    logic [23:0] exp_din;
    logic [1:0]  exp_sel;
    logic [3:0]  exp_load;
  } vec_t;
  vec_t vecs[4];

  rgb_frame_sequencer #(.TIMEOUT(16)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .i_busy       (busy),
    .o_din        (o_din),
    .o_sel        (o_sel),
    .o_load       (o_load),
    .o_frame_done (o_frame_done),
    .o_err_cnt    (o_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // All tasks start and end just after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] hdr, g, r, b, input logic [3:0] exp_load);
    exp_t e;
    e.din  = {g, r, b};
    e.sel  = hdr[1:0];
    e.load = exp_load;
    sb.push_back(e);
    send_byte(hdr);
    send_byte(g);
    send_byte(r);
    send_byte(b);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] bad_byte();
    logic [7:0] b;
    b = 8'($urandom);
    if (b[7:2] == 6'b101000) b = 8'h00;
    return b;
  endfunction

  // Scoreboard: every load pulse must match the oldest pending frame.
  always @(negedge clk) begin
    if (rst_n && (o_load != 4'h0 || o_frame_done)) begin
      if (sb.size() == 0) begin
        chk("unexpected_load", {28'h0, o_load}, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_din", {8'h0, o_din}, {8'h0, e.din});
        chk("sb_sel", {30'h0, o_sel}, {30'h0, e.sel});
        chk("sb_load", {28'h0, o_load}, {28'h0, e.load});
        chk("sb_frame_done", {31'h0, o_frame_done}, 32'h1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic hold_bad;
    logic [23:0] din_before;

    vecs[0] = '{8'hA2, 8'h11, 8'h22, 8'h33, 4'b1011, 24'h112233, 2'd2, 4'b0100};
    vecs[1] = '{8'hA0, 8'hFF, 8'h00, 8'h80, 4'b1110, 24'hFF0080, 2'd0, 4'b0001};
    vecs[2] = '{8'hA3, 8'hA0, 8'hA1, 8'hA2, 4'b0111, 24'hA0A1A2, 2'd3, 4'b1000};
    vecs[3] = '{8'hA1, 8'h5A, 8'hC3, 8'h0F, 4'b1101, 24'h5AC30F, 2'd1, 4'b0010};

    tick();
    chk("rst_din", {8'h0, o_din}, 32'h0);
    chk("rst_sel", {30'h0, o_sel}, 32'h0);
    chk("rst_load", {28'h0, o_load}, 32'h0);
    chk("rst_frame_done", {31'h0, o_frame_done}, 32'h0);
    chk("rst_err", {24'h0, o_err_cnt}, 32'h0);
    do_reset();

    // Table frames: busy on other strips must not delay the load (n+2).
    for (int i = 0; i < 4; i++) begin
      busy = vecs[i].busy;
      send_frame(vecs[i].hdr, vecs[i].g, vecs[i].r, vecs[i].b, vecs[i].exp_load);
      tick();
      chk("vec_load", {28'h0, o_load}, {28'h0, vecs[i].exp_load});
      chk("vec_din", {8'h0, o_din}, {8'h0, vecs[i].exp_din});
      tick();
      chk("vec_load_end", {28'h0, o_load}, 32'h0);
      chk("vec_din_hold", {8'h0, o_din}, {8'h0, vecs[i].exp_din});
      chk("vec_sel_hold", {30'h0, o_sel}, {30'h0, vecs[i].exp_sel});
      chk("vec_err", {24'h0, o_err_cnt}, 32'h0);
    end
    busy = 4'h0;

    // Busy strip 1 held for 50 cycles, strip 0 toggling, one overrun byte.
    do_reset();
    busy = 4'b0010;
    send_frame(8'hA1, 8'h12, 8'h34, 8'h56, 4'b0010);
    hold_bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) begin
        send_byte(8'hA2);
      end else begin
        busy[0] = ~busy[0];
        tick();
      end
      if (o_load !== 4'h0) hold_bad = 1'b1;
    end
    chk("busy_no_load", {31'h0, hold_bad}, 32'h0);
    chk("busy_overrun_err", {24'h0, o_err_cnt}, 32'h1);
    busy = 4'b0001;
    tick();
    chk("busy_release_load", {28'h0, o_load}, 32'h2);
    chk("busy_release_din", {8'h0, o_din}, 32'h123456);
    busy = 4'h0;
    tick();

    // Invalid bytes before a valid frame.
    do_reset();
    send_byte(8'h55);
    send_byte(8'hA7);
    chk("inv_err2", {24'h0, o_err_cnt}, 32'h2);
    send_frame(8'hA0, 8'hAA, 8'hBB, 8'hCC, 4'b0001);
    tick();
    chk("inv_load", {28'h0, o_load}, 32'h1);
    chk("inv_sel", {30'h0, o_sel}, 32'h0);
    tick();
    chk("inv_err_after", {24'h0, o_err_cnt}, 32'h2);

    // Timeout after header+G, then a byte landing on the expiry cycle.
    do_reset();
    send_frame(8'hA0, 8'hAA, 8'hBB, 8'hCC, 4'b0001);
    tick();
    tick();
    din_before = o_din;
    send_byte(8'hA3);
    send_byte(8'h44);
    for (int i = 0; i < 15; i++) tick();
    chk("to_before_expiry", {24'h0, o_err_cnt}, 32'h0);
    tick();
    chk("to_err", {24'h0, o_err_cnt}, 32'h1);
    tick();
    chk("to_din_kept", {8'h0, o_din}, {8'h0, din_before});
    sb.push_back('{din: 24'h778899, sel: 2'd3, load: 4'b1000});
    send_byte(8'hA3);
    send_byte(8'h77);
    for (int i = 0; i < 15; i++) tick();
    send_byte(8'h88);
    send_byte(8'h99);
    tick();
    chk("to_edge_load", {28'h0, o_load}, 32'h8);
    tick();
    chk("to_edge_err", {24'h0, o_err_cnt}, 32'h1);
    chk("to_edge_din", {8'h0, o_din}, 32'h778899);

    // Saturation, then async reset mid-frame.
    do_reset();
    for (int i = 0; i < 300; i++) send_byte(bad_byte());
    chk("sat_err", {24'h0, o_err_cnt}, 32'hFF);
    send_frame(8'hA2, 8'hDE, 8'hAD, 8'hBE, 4'b0100);
    tick();
    tick();
    chk("sat_err_hold", {24'h0, o_err_cnt}, 32'hFF);
    chk("sat_din", {8'h0, o_din}, 32'hDEADBE);
    send_byte(8'hA1);
    send_byte(8'h77);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_din", {8'h0, o_din}, 32'h0);
    chk("arst_sel", {30'h0, o_sel}, 32'h0);
    chk("arst_load", {28'h0, o_load}, 32'h0);
    chk("arst_err", {24'h0, o_err_cnt}, 32'h0);
    tick();
    rst_n = 1'b1;
    send_frame(8'hA3, 8'h01, 8'h02, 8'h03, 4'b1000);
    tick();
    chk("arst_next_load", {28'h0, o_load}, 32'h8);
    tick();
    chk("arst_next_din", {8'h0, o_din}, 32'h010203);
    chk("arst_next_err", {24'h0, o_err_cnt}, 32'h0);

    for (int i = 0; i < 5; i++) tick();
    chk("sb_empty", sb.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb_frame_sequencer.md
# rgb_frame_sequencer

Receives bytes from the UART receiver, assembles 4-byte colour frames (header + G, R, B), and drives the 4-way RGB demultiplexer's data and select inputs. It then issues a one-cycle load strobe to the addressed WS2812 strip driver once that driver is idle. It sits between the UART RX and the demultiplexer/strip-driver bank and is the only writer of strip colour.

## Interface
- TIMEOUT, 100000, inter-byte timeout in clock cycles (1 ms at 100 MHz); must be ≥ 2
- i_clk  in  1  system clock, all logic on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_rx_data  in  8  received byte, valid only while i_rx_valid high
- i_rx_valid  in  1  single-cycle strobe per received byte
- i_busy  in  4  per-strip driver busy; bit k = strip k shifting
- o_din  out  24  colour to demultiplexer, {G,R,B}, G in [23:16]
- o_sel  out  2  demultiplexer select / strip index
- o_load  out  4  one-hot, one-cycle load strobe to strip driver
- o_frame_done  out  1  one-cycle pulse, coincident with o_load
- o_err_cnt  out  8  saturating count of protocol errors

## Operation
- Frame: header byte 8'b1010_00cc (0xA0–0xA3, cc = strip), then G, R, B bytes.
- States: IDLE, GET_G, GET_R, GET_B, WAIT_IDLE, LOAD.
- IDLE: on rx_valid with i_rx_data[7:2]==6'b101000, latch ch=i_rx_data[1:0] and go to GET_G. Any other byte: stay in IDLE, err++.
- GET_G/GET_R/GET_B: each rx_valid latches its byte into the working colour register and advances. Bytes are taken as data regardless of value; there is no resync on header values.
- Timeout: the counter clears on entry to GET_G and on every accepted byte, and counts while in GET_*. On reaching TIMEOUT-1 without a byte: go to IDLE, err++, no load, working colour discarded. An rx_valid in the same cycle as expiry wins: the byte is accepted and no error is counted.
- GET_B byte accepted → WAIT_IDLE.
- WAIT_IDLE: no timeout applies. When i_busy[ch]==0, register o_din←colour and o_sel←ch, then go to LOAD.
- LOAD: o_load = one-hot(ch) and o_frame_done=1 for exactly this cycle, decoded from the state and ch registers. Return to IDLE.
- rx_valid in WAIT_IDLE or LOAD: byte dropped, err++ (overrun).
- o_err_cnt saturates at 255 and never wraps. Simultaneous error sources in one cycle count as 1.
- o_din/o_sel hold the last loaded values between frames. They change only on the WAIT_IDLE→LOAD transition.

## Timing
- Reset values: state IDLE, o_din=0, o_sel=0, o_load=0, o_frame_done=0, o_err_cnt=0, timeout counter 0, working colour 0.
- Reset assertion mid-frame aborts immediately and asynchronously. Outputs return to reset values and no load is issued.
- Latency: B byte accepted in cycle n, i_busy[ch] low at n+1 → o_din/o_sel new and o_load high in cycle n+2.
- If busy is high, the load occurs 1 cycle after the first cycle with i_busy[ch] sampled low.
- o_din/o_sel are valid in the same cycle as o_load and stay stable ≥1 cycle after it, until the next LOAD.
- Back-to-back frames: a header byte is accepted in the cycle after LOAD (state IDLE).
- Busy on other strips is ignored; only i_busy[ch] gates the load.

## Structure
- Shared package/header: state encoding, HEADER_TAG=6'b101000, colour byte order constants, error counter width.
- One sub-module: byte_timeout_timer. Inputs: clear, enable. Output: expire. Counter width $clog2(TIMEOUT); parameter TIMEOUT.
- FSM, colour assembly, and error counter live in the top module.

## Test plan
- Header 0xA2, G=0x11, R=0x22, B=0x33, busy=0 → at n+2: o_din=24'h112233, o_sel=2, o_load=4'b0100, o_frame_done=1 for one cycle, err=0.
- Header 0xA1 while i_busy[1]=1 for 50 cycles after the B byte → no load while busy; o_load=4'b0010 exactly 1 cycle after busy falls; i_busy[0] toggling has no effect.
- Bytes 0x55, 0xA7, then valid frame to strip 0 → err=2, frame loads normally, o_sel=0.
- TIMEOUT=16: header 0xA3, G, then silence → state IDLE after 16 cycles, err=1, no o_load, o_din unchanged. Repeat with a byte exactly on the expiry cycle → byte accepted, err unchanged.
- Extra byte during WAIT_IDLE (busy held) → err+1, frame still loads the original colour.
- 300 invalid bytes → o_err_cnt=255. Then an async reset pulse mid-frame → all outputs 0, next frame loads correctly.
